// File: rtl/ram_access_arbiter.sv
// ram_access_arbiter: two-port round-robin sequencer for a shared RAM on a tri-state BUS.
// Define RAM_ARB_FIXED_PRIORITY_EN to make port 0 always win contention.
module ram_access_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDRESS_WIDTH = 4
) (
  input  logic                     i_CLOCK,
  input  logic                     i_RESET,
  input  logic                     i_REQ0,
  input  logic                     i_WE0,
  input  logic [ADDRESS_WIDTH-1:0] i_ADDR0,
  input  logic [DATA_WIDTH-1:0]    i_WDATA0,
  output logic                     o_ACK0,
  input  logic                     i_REQ1,
  input  logic                     i_WE1,
  input  logic [ADDRESS_WIDTH-1:0] i_ADDR1,
  input  logic [DATA_WIDTH-1:0]    i_WDATA1,
  output logic                     o_ACK1,
  output logic [DATA_WIDTH-1:0]    o_RDATA,
  output logic                     o_GRANT,
  output logic                     o_BUSY,
  output logic [ADDRESS_WIDTH-1:0] o_MAR_DATA,
  output logic                     o_BUS_READ,
  output logic                     o_BUS_WRITE,
  inout  wire  [DATA_WIDTH-1:0]    BUS
);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
  state_t                state_q;
  logic                  we_q;
  logic                  drive_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  win_d;
`ifdef RAM_ARB_FIXED_PRIORITY_EN
  assign win_d = ~i_REQ0;
`else
  logic last_q;
  // on contention the port that did not win last time gets the RAM
  assign win_d = (i_REQ0 & i_REQ1) ? ~last_q : ~i_REQ0;
`endif
  assign BUS = drive_q ? wdata_q : 'z;
  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      drive_q     <= 1'b0;
      wdata_q     <= '0;
      o_ACK0      <= 1'b0;
      o_ACK1      <= 1'b0;
      o_RDATA     <= '0;
      o_GRANT     <= 1'b0;
      o_BUSY      <= 1'b0;
      o_MAR_DATA  <= '0;
      o_BUS_READ  <= 1'b0;
      o_BUS_WRITE <= 1'b0;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
      last_q      <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (i_REQ0 | i_REQ1) begin
          state_q    <= SETUP;
          o_GRANT    <= win_d;
          we_q       <= win_d ? i_WE1 : i_WE0;
          o_MAR_DATA <= win_d ? i_ADDR1 : i_ADDR0;
          wdata_q    <= win_d ? i_WDATA1 : i_WDATA0;
          o_BUSY     <= 1'b1;
`ifndef RAM_ARB_FIXED_PRIORITY_EN
          if (i_REQ0 & i_REQ1) last_q <= win_d;
`endif
        end
        SETUP: begin
          state_q     <= ACCESS;
          drive_q     <= we_q;
          o_BUS_READ  <= we_q;
          o_BUS_WRITE <= ~we_q;
        end
        ACCESS: begin
          state_q     <= DONE;
          drive_q     <= 1'b0;
          o_BUS_READ  <= 1'b0;
          o_BUS_WRITE <= 1'b0;
          if (!we_q) o_RDATA <= BUS;
          o_ACK0      <= ~o_GRANT;
          o_ACK1      <= o_GRANT;
        end
        DONE: begin
          state_q <= IDLE;
          o_ACK0  <= 1'b0;
          o_ACK1  <= 1'b0;
          o_BUSY  <= 1'b0;
        end
      endcase
    end
  end
endmodule
